imm_gen_pipe: RTL

//   Registered, parametrised immediate generator for the RV32I/RV64I decode stage. Decodes
//   all base formats (I, S, B, U, J, plus I-type shamt), sign-extends to XLEN and returns the

---
 rtl/imm_gen_pkg.sv | 32 +++
 rtl/imm_gen_comb.sv | 78 +++++++
 rtl/imm_gen_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the RV32I/RV64I immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  // Widen a 32-bit immediate to the largest supported XLEN; callers slice down.
  function automatic logic [63:0] sext(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_gen_comb.sv
// Purely combinational RV32I/RV64I immediate decode: instr -> imm, format tag, illegal flag.
module imm_gen_comb
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [31:0]     raw;
  logic [63:0]     wide;
  logic [XLEN-1:0] shamt;
  logic            use_shamt;

  assign opc    = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Every format is first assembled as a 32-bit word already sign-filled from instr[31].
  always_comb begin
    raw       = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    use_shamt = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        raw   = {{20{instr_i[31]}}, instr_i[31:20]};
        fmt_o = FMT_I;
      end
      OPC_OPIMM: begin
        raw       = {{20{instr_i[31]}}, instr_i[31:20]};
        fmt_o     = FMT_I;
        use_shamt = (funct3 == F3_SLLI) || (funct3 == F3_SRXI);
      end
      OPC_STORE: begin
        raw   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        fmt_o = FMT_S;
      end
      OPC_BRANCH: begin
        raw   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
        fmt_o = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        raw   = {instr_i[31:12], 12'b0};
        fmt_o = FMT_U;
      end
      OPC_JAL: begin
        raw   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
        fmt_o = FMT_J;
      end
      OPC_OP: begin
        fmt_o = FMT_R;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  always_comb begin
    shamt = '0;
    if (XLEN == 64) begin
      shamt[5:0] = instr_i[25:20];
    end else begin
      shamt[4:0] = instr_i[24:20];
    end
  end

  assign wide  = sext(raw);
  assign imm_o = use_shamt ? shamt : wide[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake, stall hold and flush.
// Optional PC-relative target adder enabled by defining IMM_GEN_TARGET_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output fmt_e            fmt_out,
  output logic            illegal_out,
  output logic [PC_W-1:0] target_out
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;

  imm_gen_comb #(.XLEN(XLEN)) u_dec (
    .instr_i   (instr_in),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  logic            valid_q, valid_d;
  logic [XLEN-1:0] imm_q, imm_d;
  fmt_e            fmt_q, fmt_d;
  logic            ill_q, ill_d;
  logic            accept, load;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Flush wins over a simultaneous accept; payload registers are left untouched on a kill.
  always_comb begin
    valid_d = valid_q;
    load    = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      load    = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    imm_d = imm_q;
    fmt_d = fmt_q;
    ill_d = ill_q;
    if (load) begin
      imm_d = dec_imm;
      fmt_d = dec_fmt;
      ill_d = dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      fmt_q   <= FMT_NONE;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      fmt_q   <= fmt_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid   = valid_q;
  assign imm_out     = imm_q;
  assign fmt_out     = fmt_q;
  assign illegal_out = ill_q;

`ifdef IMM_GEN_TARGET_EN
  logic [PC_W-1:0] imm_pc;
  logic [PC_W-1:0] target_q, target_d;

  generate
    if (PC_W <= XLEN) begin : g_imm_trunc
      assign imm_pc = dec_imm[PC_W-1:0];
    end else begin : g_imm_ext
      assign imm_pc = {{(PC_W-XLEN){dec_imm[XLEN-1]}}, dec_imm};
    end
  endgenerate

  always_comb begin
    target_d = target_q;
    if (load) begin
      target_d = pc_in + imm_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= '0;
    end else begin
      target_q <= target_d;
    end
  end

  assign target_out = target_q;
`else
  logic unused_pc;
  assign unused_pc  = ^pc_in;
  assign target_out = '0;
`endif

endmodule
